// File: rtl/rv32i_types.sv
// Shared RV32 type definitions used by the execute-stage units.
package rv32i_types;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_t;

  function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage handshake between the pipeline control and the RV32M unit.
interface ex_muldiv_if;
  import rv32i_types::*;

  logic           start;
  muldiv_funct3_t funct3;
  logic [31:0]    rs1_data;
  logic [31:0]    rs2_data;
  logic           flush;
  logic           stall;
  logic           done;
  logic [31:0]    result;

  modport master (
    output start, funct3, rs1_data, rs2_data, flush,
    input  stall, done, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, flush,
    output stall, done, result
  );

endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M unit: 32-cycle shift-add multiply and restoring divide
// sharing one 64-bit accumulator, iteration counter and final negate.
module ex_muldiv
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t         state;
  logic [5:0]     cnt;
  logic [63:0]    acc;
  logic [31:0]    opnd;
  logic           neg;
  muldiv_funct3_t op;
  logic [31:0]    result_q;
  logic           done_q;

  function automatic logic [63:0] negate(input logic [63:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic [2:0]  f3;
  logic [31:0] a, b, a_mag, b_mag, special_val;
  logic        a_signed, b_signed, neg_in, div_zero, ovf, special;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [63:0] step_acc, fin;
  logic [31:0] fin_result;

  // Operand conditioning for the instruction waiting in IDLE
  always_comb begin
    f3       = bus.funct3;
    a        = bus.rs1_data;
    b        = bus.rs2_data;
    a_signed = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    b_signed = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    a_mag    = mag_of(a, a_signed);
    b_mag    = mag_of(b, b_signed);
    // Remainder takes the dividend's sign; everything else the product of signs
    neg_in   = (f3 == F3_REM) ? a[31] : ((a_signed & a[31]) ^ (b_signed & b[31]));
    div_zero = f3[2] && (b == 32'd0);
    ovf      = f3[2] && !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special  = div_zero || ovf;
    if (div_zero) special_val = f3[1] ? a : 32'hFFFF_FFFF;
    else          special_val = f3[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration of the shared datapath plus the signed fix-up of its output
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_diff = {1'b0, acc[63:31]} - {2'b00, opnd};
    step_acc = acc;
    if (state == MUL)
      step_acc = {mul_sum, acc[31:1]};
    else if (state == DIV)
      step_acc = div_diff[33] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
    if (state == MUL)
      fin = negate(step_acc, neg);
    else
      fin = negate({32'd0, op[1] ? step_acc[63:32] : step_acc[31:0]}, neg);
    fin_result = (state == MUL && op != F3_MUL) ? fin[63:32] : fin[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      neg      <= 1'b0;
      op       <= F3_MUL;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              op  <= bus.funct3;
              neg <= neg_in;
              cnt <= 6'd0;
              if (special) begin
                result_q <= special_val;
                done_q   <= 1'b1;
                state    <= DONE;
              end else if (f3[2]) begin
                acc   <= {32'd0, a_mag};
                opnd  <= b_mag;
                state <= DIV;
              end else begin
                acc   <= {32'd0, b_mag};
                opnd  <= a_mag;
                state <= MUL;
              end
            end
          end
          MUL, DIV: begin
            acc <= step_acc;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              result_q <= fin_result;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.stall  = (state == IDLE && bus.start) || state == MUL || state == DIV;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table plus flush/reset/back-to-back sequences.
module tb_ex_muldiv;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_if bus ();
  ex_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int passed = 0;
  logic [31:0] last_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.funct3   = F3_MUL;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    bus.flush    = 1'b0;
  endtask

  // Presents an op and holds it until done; lat counts edges from the accepting edge
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int pre,
                        output logic stall_ok);
    bus.start    = 1'b1;
    bus.funct3   = muldiv_funct3_t'(f3);
    bus.rs1_data = a;
    bus.rs2_data = b;
    stall_ok = 1'b1;
    pre = 0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    #1;
    while (!bus.stall && pre < 4) begin
      @(posedge clk); #1;
      pre++;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        res = bus.result;
        if (bus.stall) stall_ok = 1'b0;
        break;
      end
      if (!bus.stall) stall_ok = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (bus.done) n++;
    end
  endtask

  logic [31:0] res;
  int lat, pre, n;
  logic sok;

  initial begin
    idle_inputs();
    vecs.push_back('{3'b000, 32'd7,         32'd6,         32'h0000_002A, 33});
    vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33});
    vecs.push_back('{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 33});
    vecs.push_back('{3'b001, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        33});
    vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         33});
    vecs.push_back('{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33});
    vecs.push_back('{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'b111, 32'd5,         32'd0,         32'd5,         1});
    vecs.push_back('{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1});
    vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33});
    vecs.push_back('{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33});
    vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33});

    // Reset state
    #12;
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, pre, sok);
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_stall", i), {31'd0, sok}, 32'd1);
      last_res = vecs[i].exp;
      @(negedge clk);
    end

    // Flush at iteration 10 of a DIV
    bus.start = 1'b1; bus.funct3 = F3_DIV; bus.rs1_data = 32'd100; bus.rs2_data = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("flush_done", {31'd0, bus.done}, 32'd0);
    check("flush_stall", {31'd0, bus.stall}, 32'd0);
    check("flush_result", bus.result, last_res);
    bus.flush = 1'b0;
    count_done(40, n);
    check("flush_no_done", n, 0);
    check("flush_result_hold", bus.result, last_res);
    run_op(3'b000, 32'd3, 32'd3, res, lat, pre, sok);
    check("post_flush_mul", res, 32'd9);
    check("post_flush_lat", lat, 33);

    // Reset in the middle of a MUL
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = F3_MUL; bus.rs1_data = 32'd11; bus.rs2_data = 32'd13;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_stall", {31'd0, bus.stall}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_done(40, n);
    check("midrst_no_done", n, 0);

    // Back-to-back MUL then DIVU with no idle gap
    @(negedge clk);
    run_op(3'b000, 32'd12, 32'd10, res, lat, pre, sok);
    check("b2b_mul", res, 32'd120);
    run_op(3'b101, 32'd100, 32'd7, res, lat, pre, sok);
    check("b2b_divu", res, 32'd14);
    check("b2b_gap", pre, 1);
    check("b2b_lat", lat, 33);
    check("b2b_stall", {31'd0, sok}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  EX-stage instruction is an RV32M op (from ctrl_ex), held stable by the ID/EX register while stall=1.
REQ-005 funct3  input  3  M-op select, type muldiv_funct3_t.
REQ-006 rs1_data  input  32  operand A (dividend / multiplicand).
REQ-007 rs2_data  input  32  operand B (divisor / multiplier).
REQ-008 flush  input  1  synchronous abort from branch/exception redirect.
REQ-009 stall  output  1  hold ID/EX and upstream registers (drives their load low).
REQ-010 done  output  1  single-cycle pulse: result valid for the EX instruction.
REQ-011 result  output  32  registered M-op result.

Function
REQ-012 Ops SHALL be: 000 MUL (low 32), 001 MULH (s*s high), 010 MULHSU (s*u high), 011 MULHU (u*u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-013 FSM states SHALL be IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-014 IDLE: start=1 and no special case -> MUL (funct3[2]=0) or DIV (funct3[2]=1); operands latched as magnitudes, result sign latched, 6-bit iteration counter cleared.
REQ-015 MUL SHALL run shift-add over a 64-bit accumulator, one multiplier bit per cycle, 32 cycles, then -> DONE.
REQ-016 DIV SHALL run restoring division, one quotient bit per cycle, 32 cycles, then -> DONE.
REQ-017 Signed ops SHALL operate on magnitudes and negate the final value when the latched sign is 1; REM sign follows the dividend, DIV sign is the XOR of operand signs.
REQ-018 Special cases SHALL go IDLE -> DONE directly: divide by zero gives quotient 0xFFFFFFFF and remainder = rs1_data; signed overflow (0x80000000 / 0xFFFFFFFF) gives quotient 0x80000000 and remainder 0.
REQ-019 Latency: done=1 exactly 33 cycles after the accepting edge for iterative ops, and 1 cycle after for special cases.
REQ-020 stall SHALL be combinational: 1 when (IDLE and start) or state is MUL/DIV; 0 in DONE.
REQ-021 DONE SHALL assert done for one cycle, ignore start (same instruction still present), and -> IDLE.
REQ-022 result SHALL update only on entry to DONE and otherwise hold its value.
REQ-023 flush=1 SHALL force -> IDLE on the next edge from any state, suppress done, and leave result unchanged; flush wins over start.
REQ-024 A start arriving in the cycle after DONE (IDLE) SHALL be accepted normally (back-to-back ops, no bubble).

Reset
REQ-025 rst SHALL asynchronously force state=IDLE, counter=0, accumulators=0, result=0, done=0; stall follows REQ-020 (0 unless start).
REQ-026 Reset asserted mid-operation SHALL discard the operation; done SHALL not pulse for it after reset release.

Structure
REQ-027 muldiv_funct3_t (enumerating the eight ops) SHALL live in rv32i_types; the FSM state enum SHALL be local to the module.
REQ-028 The block SHALL be a single module with no sub-modules; the mul and div datapaths share the counter and the negate logic.

Verification
REQ-029 MUL rs1=7, rs2=6 -> stall for 33 cycles, done at cycle 33, result=0x0000002A.
REQ-030 MULH 0x80000000 x 0x80000000 -> result=0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-032 DIVU 5/0 -> done 1 cycle after start, result 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 Flush asserted at iteration 10 of DIV -> IDLE next cycle, no done, result keeps its prior value; a new MUL 3x3 issued right after -> 9.
REQ-034 rst pulsed mid-MUL -> all outputs 0 immediately; back-to-back MUL then DIVU 100/7 -> 14 with no idle gap.
